// File: rtl/param_shift_engine.sv
// ---------------------------------------------------------------------------
// param_shift_engine
//
// Parametrised shift datapath. A parallel load writes the data register
// directly. A start command runs a burst of single-position shifts, counted
// down one per clock, with a busy/done handshake around the burst.
//
// Shift modes: logical, rotate and arithmetic. Each can go left or right.
// Logical shifts take their fill bit from serial_in on every shift edge.
//
// Parameters:
//    WIDTH  - data register width in bits (>= 2)
//    CNT_W  - width of the burst count; longest burst is 2**CNT_W-1 shifts
//
// Ports:
//    clk        - system clock, rising-edge active
//    rst        - synchronous reset, active-high
//    load       - parallel-load request (honoured in IDLE/DONE only)
//    load_data  - value written into q on an accepted load
//    start      - begin a shift burst (honoured in IDLE/DONE, when load=0)
//    count      - number of shifts in the burst, latched on accepted start
//    mode       - 00 logical, 01 rotate, 10 arithmetic, 11 logical
//    dir        - 0 shifts toward the MSB, 1 shifts toward the LSB
//    serial_in  - fill bit for logical shifts
//    q          - data register
//    serial_out - bit expelled by the most recent shift
//    busy       - high while a burst is in progress
//    done       - one-cycle pulse after a burst (or a zero-length start)
// ---------------------------------------------------------------------------
module param_shift_engine #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic [1:0]       mode,
   input  logic             dir,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam logic [1:0] MODE_LOGICAL = 2'b00;
   localparam logic [1:0] MODE_ROTATE  = 2'b01;
   localparam logic [1:0] MODE_ARITH   = 2'b10;

   state_t           state;
   logic [CNT_W-1:0] remaining;
   logic [1:0]       mode_r;
   logic             dir_r;

   logic [WIDTH-1:0] shift_q;
   logic             shift_out;

   // Next value of q, and the bit it pushes out, for a single shift position
   // using the burst's latched mode and direction. The reserved mode code
   // falls through to the logical shift on purpose.
   always_comb begin
      shift_q   = q;
      shift_out = 1'b0;
      case (mode_r)
         MODE_ROTATE: begin
            if (dir_r) begin
               shift_q   = {q[0], q[WIDTH-1:1]};
               shift_out = q[0];
            end else begin
               shift_q   = {q[WIDTH-2:0], q[WIDTH-1]};
               shift_out = q[WIDTH-1];
            end
         end
         MODE_ARITH: begin
            // A left arithmetic shift is a logical shift that always fills
            // with zero, so serial_in does not enter this path.
            if (dir_r) begin
               shift_q   = {q[WIDTH-1], q[WIDTH-1:1]};
               shift_out = q[0];
            end else begin
               shift_q   = {q[WIDTH-2:0], 1'b0};
               shift_out = q[WIDTH-1];
            end
         end
         default: begin
            if (dir_r) begin
               shift_q   = {serial_in, q[WIDTH-1:1]};
               shift_out = q[0];
            end else begin
               shift_q   = {q[WIDTH-2:0], serial_in};
               shift_out = q[WIDTH-1];
            end
         end
      endcase
   end

   // Control FSM and datapath registers. busy and done are registered
   // decodes of the next state, so they line up exactly with the state.
   // IDLE and DONE both accept commands; DONE never lasts more than a cycle.
   // The last shift happens on the edge where remaining is 1. That shift
   // moves straight to DONE, so the final q and done appear together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         q          <= '0;
         serial_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         remaining  <= '0;
         mode_r     <= MODE_LOGICAL;
         dir_r      <= 1'b0;
      end else begin
         case (state)
            SHIFT: begin
               q          <= shift_q;
               serial_out <= shift_out;
               remaining  <= remaining - 1'b1;
               if (remaining == CNT_W'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               if (load) begin
                  q     <= load_data;
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end else if (start && (count != '0)) begin
                  remaining <= count;
                  mode_r    <= mode;
                  dir_r     <= dir;
                  state     <= SHIFT;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end else if (start) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_param_shift_engine.sv
// ---------------------------------------------------------------------------
// tb_param_shift_engine
//
// Directed testbench for param_shift_engine with WIDTH=8 and CNT_W=4.
// Inputs change 1ns after each rising edge. Outputs are sampled at the same
// point, so every check sees the state left by the preceding edge.
// ---------------------------------------------------------------------------
module tb_param_shift_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [7:0] load_data;
   logic       start;
   logic [3:0] count;
   logic [1:0] mode;
   logic       dir;
   logic       serial_in;
   logic [7:0] q;
   logic       serial_out;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   param_shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_data  (load_data),
      .start      (start),
      .count      (count),
      .mode       (mode),
      .dir        (dir),
      .serial_in  (serial_in),
      .q          (q),
      .serial_out (serial_out),
      .busy       (busy),
      .done       (done)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Advance one clock edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply a one-cycle parallel load
   task automatic do_load(input logic [7:0] value);
      load      = 1'b1;
      load_data = value;
      tick();
      load      = 1'b0;
   endtask

   // Apply a one-cycle start command
   task automatic do_start(input logic [3:0] cnt, input logic [1:0] md,
                           input logic dr);
      start = 1'b1;
      count = cnt;
      mode  = md;
      dir   = dr;
      tick();
      start = 1'b0;
   endtask

   // Reset from a non-zero state
   task automatic test_reset();
      do_load(8'hFF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (q !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_q: got %h expected 00", q);
      end
      checks++;
      if ({serial_out, busy, done} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_flags: got so/busy/done %b expected 000",
                  {serial_out, busy, done});
      end
   endtask

   // Logical left burst with serial fill of 1
   task automatic test_logical_left();
      logic [7:0] exp_seq [3];
      exp_seq[0] = 8'h4B;
      exp_seq[1] = 8'h97;
      exp_seq[2] = 8'h2F;
      do_load(8'hA5);
      serial_in = 1'b1;
      do_start(4'd3, 2'b00, 1'b0);
      checks++;
      if (busy !== 1'b1 || q !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL ll_start: got busy=%b q=%h expected busy=1 q=a5",
                  busy, q);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (q !== exp_seq[i] || busy !== (i < 2) || done !== (i == 2)) begin
            errors++;
            $display("[TB] FAIL ll_step%0d: got q=%h busy=%b done=%b expected q=%h busy=%b done=%b",
                     i, q, busy, done, exp_seq[i], (i < 2), (i == 2));
         end
      end
      checks++;
      if (serial_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ll_serial_out: got %b expected 1", serial_out);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ll_done_pulse: got busy=%b done=%b expected 0 0",
                  busy, done);
      end
      serial_in = 1'b0;
   endtask

   // Arithmetic right; serial_out must hold across the load before it
   task automatic test_arith_right();
      do_load(8'h90);
      checks++;
      if (serial_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ar_so_hold: got %b expected 1", serial_out);
      end
      serial_in = 1'b1;
      do_start(4'd2, 2'b10, 1'b1);
      tick();
      checks++;
      if (q !== 8'hC8 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ar_step0: got q=%h busy=%b expected q=c8 busy=1",
                  q, busy);
      end
      tick();
      checks++;
      if (q !== 8'hE4 || done !== 1'b1 || busy !== 1'b0 || serial_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ar_step1: got q=%h done=%b busy=%b so=%b expected q=e4 done=1 busy=0 so=0",
                  q, done, busy, serial_out);
      end
      serial_in = 1'b0;
   endtask

   // Rotate bursts, including a full-width rotate back to the start value
   task automatic test_rotate();
      int busy_cycles;
      bit seen_done;
      do_load(8'h3C);
      do_start(4'd4, 2'b01, 1'b0);
      seen_done = 1'b0;
      for (int i = 0; i < 40 && !seen_done; i++) begin
         tick();
         if (done) seen_done = 1'b1;
      end
      checks++;
      if (!seen_done || q !== 8'hC3) begin
         errors++;
         $display("[TB] FAIL rot_left4: got q=%h done_seen=%b expected q=c3 done_seen=1",
                  q, seen_done);
      end
      do_load(8'h3C);
      do_start(4'd8, 2'b01, 1'b1);
      busy_cycles = 0;
      seen_done   = 1'b0;
      if (busy) busy_cycles++;
      for (int i = 0; i < 40 && !seen_done; i++) begin
         tick();
         if (busy) busy_cycles++;
         if (done) seen_done = 1'b1;
      end
      checks++;
      if (!seen_done || q !== 8'h3C) begin
         errors++;
         $display("[TB] FAIL rot_right8: got q=%h done_seen=%b expected q=3c done_seen=1",
                  q, seen_done);
      end
      checks++;
      if (busy_cycles !== 8) begin
         errors++;
         $display("[TB] FAIL rot_busy_len: got %0d expected 8", busy_cycles);
      end
   endtask

   // Load and start together: load wins and the start is dropped
   task automatic test_load_start();
      load      = 1'b1;
      load_data = 8'h5A;
      start     = 1'b1;
      count     = 4'd3;
      mode      = 2'b00;
      dir       = 1'b0;
      tick();
      load  = 1'b0;
      start = 1'b0;
      checks++;
      if (q !== 8'h5A || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL load_start: got q=%h busy=%b done=%b expected q=5a busy=0 done=0",
                  q, busy, done);
      end
      tick();
      checks++;
      if (q !== 8'h5A || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL load_start_after: got q=%h busy=%b expected q=5a busy=0",
                  q, busy);
      end
   endtask

   // Zero-length burst: one-cycle done, busy never rises
   task automatic test_count_zero();
      do_start(4'd0, 2'b00, 1'b0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h5A) begin
         errors++;
         $display("[TB] FAIL cnt0: got done=%b busy=%b q=%h expected done=1 busy=0 q=5a",
                  done, busy, q);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL cnt0_after: got done=%b busy=%b expected 0 0",
                  done, busy);
      end
   endtask

   // Load request mid-burst is ignored
   task automatic test_load_during_shift();
      do_load(8'h81);
      serial_in = 1'b0;
      do_start(4'd2, 2'b00, 1'b0);
      load      = 1'b1;
      load_data = 8'hFF;
      tick();
      checks++;
      if (q !== 8'h02 || serial_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL lds_step0: got q=%h so=%b expected q=02 so=1",
                  q, serial_out);
      end
      tick();
      load = 1'b0;
      checks++;
      if (q !== 8'h04 || done !== 1'b1 || serial_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL lds_step1: got q=%h done=%b so=%b expected q=04 done=1 so=0",
                  q, done, serial_out);
      end
   endtask

   // Reset in the second busy cycle aborts the burst with no done pulse
   task automatic test_reset_mid_burst();
      bit saw_done;
      do_load(8'h0F);
      serial_in = 1'b0;
      do_start(4'd5, 2'b00, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || serial_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_mid: got q=%h busy=%b done=%b so=%b expected 00 0 0 0",
                  q, busy, done, serial_out);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done || busy) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("[TB] FAIL rst_mid_quiet: got activity=1 expected activity=0");
      end
      serial_in = 1'b1;
      do_start(4'd1, 2'b00, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rst_next_busy: got %b expected 1", busy);
      end
      tick();
      checks++;
      if (q !== 8'h01 || done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_next_done: got q=%h done=%b busy=%b expected q=01 done=1 busy=0",
                  q, done, busy);
      end
   endtask

   // Test sequence
   initial begin
      rst       = 1'b1;
      load      = 1'b0;
      load_data = 8'h00;
      start     = 1'b0;
      count     = 4'd0;
      mode      = 2'b00;
      dir       = 1'b0;
      serial_in = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      test_reset();
      test_logical_left();
      test_arith_right();
      test_rotate();
      test_load_start();
      test_count_zero();
      test_load_during_shift();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/param_shift_engine.md
Name: param_shift_engine

Overview:
- Parametrised successor to the 8-bit load/shift-left register.
- Generalised width; left/right direction; logical, rotate and arithmetic modes; serial input fill.
- Multi-cycle shift bursts driven by a down-counter and a small FSM, with busy/done handshake.
- Sits between the pin interface (parallel load from ui_in, control from uio_in) and uo_out, as the shift datapath of the top level.

Parameters:
- WIDTH, 8, data register width in bits (>=2).
- CNT_W, 4, width of burst shift-count input; max burst = 2^CNT_W-1 shifts.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- load  input  1  parallel-load request.
- load_data  input  WIDTH  value loaded into q on accepted load.
- start  input  1  begin shift burst.
- count  input  CNT_W  number of shifts in burst; latched on accepted start.
- mode  input  2  00 logical, 01 rotate, 10 arithmetic, 11 reserved (treated as logical); latched on accepted start.
- dir  input  1  0 = left (toward MSB), 1 = right; latched on accepted start.
- serial_in  input  1  fill bit for logical shifts; sampled on every shift edge.
- q  output  WIDTH  data register.
- serial_out  output  1  registered copy of the bit expelled by the most recent shift.
- busy  output  1  high while FSM in SHIFT.
- done  output  1  one-cycle pulse while FSM in DONE.

Behaviour:
- Reset (rst=1 at edge): q=0, serial_out=0, busy=0, done=0, remaining-count=0, state IDLE. Takes priority over everything, including mid-burst.
- States: IDLE, SHIFT, DONE. busy = (state==SHIFT), done = (state==DONE), both registered state decodes.
- IDLE and DONE accept commands identically; DONE always exits after one cycle.
  - load=1: q<=load_data; next state IDLE. load beats start when both are high; that start is dropped.
  - start=1, load=0, count!=0: latch count/mode/dir; next state SHIFT. q unchanged on this edge.
  - start=1, load=0, count==0: next state DONE (1-cycle done, busy never asserts); q unchanged.
  - Neither: DONE->IDLE, IDLE stays.
- SHIFT: one shift per edge, remaining decrements.
  - Edge where remaining==1 performs the last shift and moves to DONE.
  - Latency: start sampled at edge T; shifts on edges T+1..T+count; busy high for exactly count cycles; done high for the cycle after edge T+count, with final q valid simultaneously.
- load and start are ignored while in SHIFT (no queuing). Changes to mode/dir/count mid-burst have no effect.
- Shift rules, one position per edge:
  - logical left: q<={q[W-2:0],serial_in}, out=q[W-1].
  - logical right: q<={serial_in,q[W-1:1]}, out=q[0].
  - rotate left/right: expelled bit re-enters the opposite end; out = expelled bit.
  - arithmetic right: MSB replicated, out=q[0]. Arithmetic left behaves as logical left with 0 fill (serial_in ignored).
- serial_out updates only on shift edges. It holds its value across load, IDLE and DONE.
- count > WIDTH is legal: logical shifts saturate to all-fill; rotate wraps modulo WIDTH.

Test Plan (WIDTH=8, CNT_W=4):
- Reset: assert rst 1 cycle from arbitrary state -> q=0x00, serial_out=0, busy=0, done=0.
- Load 0xA5, then start count=3, logical, left, serial_in=1 -> q sequence 0x4B, 0x97, 0x2F; busy high 3 cycles; done pulse with q=0x2F; serial_out=1.
- Load 0x90, start count=2, arithmetic, right -> 0xC8 then 0xE4; serial_out=0; done after 2 busy cycles.
- Load 0x3C:
  - Rotate left count=4 -> q=0xC3.
  - Reload 0x3C, rotate right count=8 -> q=0x3C; busy exactly 8 cycles.
- Load and start in the same cycle -> q=load_data, no burst.
- start count=0 -> done one cycle, busy stays 0, q unchanged.
- Load pulse during SHIFT -> ignored, burst result unaffected.
- Start count=5, assert rst at the 2nd busy cycle -> q=0, busy=0, done=0, no done pulse. The next start count=1 completes normally.
